axi_mem_sub: RTL
================

# axi_mem_sub

AXI4 subordinate memory model that terminates the manager port of a CPU multisim server: accepts AW/W/AR traffic, stores write data in an internal word array, and returns B and R responses. Independent write and read engines each hold one transaction in flight. Out-of-range accesses and unsupported bursts complete with SLVERR. Sits in the simulation top between a CPU server instance and the rest of the testbench.

## Interface
- DEPTH, 4096: memory size in DATA_W-bit words.
- BASE_ADDR, 64'h8000_0000: byte address of word 0; must be DATA_W/8 aligned.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- i_axi_s_aw  in  axi_aw_t  write address (id, addr, len, size, burst).
- i_axi_s_awvalid  in  1 / o_axi_s_awready  out  1.
- i_axi_s_w  in  axi_w_t  write data (data, strb, last).
- i_axi_s_wvalid  in  1 / o_axi_s_wready  out  1.
- o_axi_s_b  out  axi_b_t  write response (id, resp).
- o_axi_s_bvalid  out  1 / i_axi_s_bready  in  1.
- i_axi_s_ar  in  axi_ar_t  read address (fields as AW).
- i_axi_s_arvalid  in  1 / o_axi_s_arready  out  1.
- o_axi_s_r  out  axi_r_t  read data (id, data, resp, last).
- o_axi_s_rvalid  out  1 / i_axi_s_rready  in  1.

## Operation
- Write FSM: W_IDLE -> (AW handshake) W_DATA -> (beat with count == len accepted) W_RESP -> (B handshake) W_IDLE.
- Read FSM: R_IDLE -> (AR handshake) R_DATA -> (beat with last accepted) R_IDLE.
- awready = 1 only in W_IDLE; wready = 1 only in W_DATA; arready = 1 only in R_IDLE.
- Beat address: FIXED keeps addr; INCR adds 2^size per beat; word index = (addr - BASE_ADDR) >> log2(DATA_W/8). Address arithmetic ADDR_W bits, wraps modulo 2^ADDR_W.
- Error (resp = SLVERR): any beat index >= DEPTH or addr < BASE_ADDR, burst = WRAP/reserved, or size > log2(DATA_W/8). Errored write beats are dropped; errored read beats return data 0. B resp is SLVERR if any beat of the burst errored, else OKAY. Per-beat R resp.
- Writes honour strb per byte lane.
- Memory initialised to 0 at time 0; not cleared by reset.
- Same-cycle write beat and read beat to one word: read returns pre-write value.

## Timing
- Reset values: all ready/valid outputs 0, b/r payloads 0, both FSMs idle, beat counters 0.
- Reset mid-burst: transaction abandoned, no B/R issued afterwards; partial writes already stored remain.
- AR handshake at cycle N -> first rvalid at N+1; each further beat one cycle after the previous R handshake (full throughput under rready=1). rvalid/payload held stable while rready=0.
- Last W beat accepted at cycle N -> bvalid at N+1, held until bready.
- len+1 beats per burst, len 0..255; last asserted on beat len.
- Write and read engines never stall each other.

## Configuration
- AXI_MEM_SUB_PROTO_CHECK_EN defined: wlast compared with beat counter; mismatch forces B resp SLVERR and emits $error; awvalid/arvalid payload stability checked by assertions.
- Undefined: wlast ignored, beat count alone terminates the burst; no assertions.

## Structure
- axi_pkg holds axi_aw_t, axi_w_t, axi_b_t, axi_ar_t, axi_r_t, ADDR_W=64, DATA_W=64, ID_W=4, burst encodings (FIXED=0, INCR=1, WRAP=2), resp encodings (OKAY=0, SLVERR=2).
- One sub-module: axi_mem_sub_addr_gen (start addr, size, burst, beat count -> beat addr, in-range flag), instantiated once per engine.

## Test plan
- Single write addr BASE+0x10, data 64'hDEAD_BEEF_0123_4567, strb 8'hFF, then read same -> B OKAY at N+1, R data matches, rlast=1.
- INCR write len=3 size=3 at BASE, strb 8'h0F on beat 2, then read len=3 -> beat 2 upper 32 bits 0, others match.
- Write to BASE+DEPTH*8 -> B SLVERR, memory unchanged; read there -> data 0, resp SLVERR.
- Read len=7 with rready toggling every cycle -> 8 beats, payload stable under stall, last only on beat 7.
- WRAP burst AR -> all beats SLVERR, FSM returns to R_IDLE.
- Assert rst_n low during beat 2 of write len=3 -> all outputs 0 next edge, no B after release; new write completes normally.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI4 channel types, widths and encodings for the memory subordinate.
package axi_pkg;

  localparam int ADDR_W   = 64;
  localparam int DATA_W   = 64;
  localparam int ID_W     = 4;
  localparam int STRB_W   = DATA_W / 8;
  localparam int SIZE_MAX = $clog2(STRB_W);

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
  } axi_aw_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
  } axi_ar_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
    logic              last;
  } axi_w_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
  } axi_b_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } axi_r_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_e;

endpackage

// File: rtl/axi_mem_sub_addr_gen.sv
// Per-beat address generator: start address, size, burst and beat number in,
// word index plus range/legality flags out.
module axi_mem_sub_addr_gen
  import axi_pkg::*;
#(
  parameter int                DEPTH     = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 64'h8000_0000,
  parameter int                IDX_W     = $clog2(DEPTH)
) (
  input  logic [ADDR_W-1:0] i_start_addr,
  input  logic [2:0]        i_size,
  input  logic [1:0]        i_burst,
  input  logic [7:0]        i_beat_cnt,
  output logic [IDX_W-1:0]  o_word_idx,
  output logic              o_in_range,
  output logic              o_legal
);

  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] beat_addr;
  logic [ADDR_W-1:0] idx_full;

  always_comb begin
    offset    = ADDR_W'(i_beat_cnt) << i_size;
    beat_addr = (i_burst == BURST_FIXED) ? i_start_addr : i_start_addr + offset;
    // An address below the base wraps to a huge index, but is rejected explicitly anyway.
    idx_full   = (beat_addr - BASE_ADDR) >> SIZE_MAX;
    o_word_idx = idx_full[IDX_W-1:0];
    o_in_range = (beat_addr >= BASE_ADDR) && (idx_full < ADDR_W'(DEPTH));
    o_legal    = ((i_burst == BURST_FIXED) || (i_burst == BURST_INCR)) &&
                 (i_size <= 3'(SIZE_MAX));
  end

endmodule

// File: rtl/axi_mem_sub.sv
// AXI4 subordinate memory model with independent single-outstanding write and read engines.
// Optional AXI_MEM_SUB_PROTO_CHECK_EN adds wlast checking and AW/AR stability assertions.
module axi_mem_sub
  import axi_pkg::*;
#(
  parameter int                DEPTH     = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 64'h8000_0000
) (
  input  logic    clk,
  input  logic    rst_n,
  input  axi_aw_t i_axi_s_aw,
  input  logic    i_axi_s_awvalid,
  output logic    o_axi_s_awready,
  input  axi_w_t  i_axi_s_w,
  input  logic    i_axi_s_wvalid,
  output logic    o_axi_s_wready,
  output axi_b_t  o_axi_s_b,
  output logic    o_axi_s_bvalid,
  input  logic    i_axi_s_bready,
  input  axi_ar_t i_axi_s_ar,
  input  logic    i_axi_s_arvalid,
  output logic    o_axi_s_arready,
  output axi_r_t  o_axi_s_r,
  output logic    o_axi_s_rvalid,
  input  logic    i_axi_s_rready
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  // Holds the address-ready outputs low until the first edge after reset release.
  logic init_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) init_done_q <= 1'b0;
    else        init_done_q <= 1'b1;
  end

  // ---------------- write engine ----------------
  w_state_e   w_state_q, w_state_d;
  axi_aw_t    aw_q, aw_d;
  logic [7:0] w_cnt_q, w_cnt_d;
  logic       w_err_q, w_err_d;
  axi_b_t     b_q, b_d;
  logic       bvalid_q, bvalid_d;

  logic [IDX_W-1:0] w_idx;
  logic             w_in_range, w_legal, w_beat_err;
  logic             w_last_mismatch;
  logic             mem_we;

  axi_mem_sub_addr_gen #(
    .DEPTH    (DEPTH),
    .BASE_ADDR(BASE_ADDR),
    .IDX_W    (IDX_W)
  ) u_w_addr_gen (
    .i_start_addr(aw_q.addr),
    .i_size      (aw_q.size),
    .i_burst     (aw_q.burst),
    .i_beat_cnt  (w_cnt_q),
    .o_word_idx  (w_idx),
    .o_in_range  (w_in_range),
    .o_legal     (w_legal)
  );

  assign w_beat_err      = !w_in_range || !w_legal;
  assign o_axi_s_awready = init_done_q && (w_state_q == W_IDLE);
  assign o_axi_s_wready  = (w_state_q == W_DATA);
  assign o_axi_s_b       = b_q;
  assign o_axi_s_bvalid  = bvalid_q;

`ifdef AXI_MEM_SUB_PROTO_CHECK_EN
  assign w_last_mismatch = i_axi_s_w.last != (w_cnt_q == aw_q.len);
`else
  logic unused_wlast;
  assign w_last_mismatch = 1'b0;
  assign unused_wlast    = i_axi_s_w.last;
`endif

  always_comb begin
    w_state_d = w_state_q;
    aw_d      = aw_q;
    w_cnt_d   = w_cnt_q;
    w_err_d   = w_err_q;
    b_d       = b_q;
    bvalid_d  = bvalid_q;
    mem_we    = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if (i_axi_s_awvalid && o_axi_s_awready) begin
          aw_d      = i_axi_s_aw;
          w_cnt_d   = 8'd0;
          w_err_d   = 1'b0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (i_axi_s_wvalid) begin
          mem_we = !w_beat_err;
          if (w_beat_err || w_last_mismatch) w_err_d = 1'b1;
          // The beat count alone ends the burst; wlast only feeds the error flag.
          if (w_cnt_q == aw_q.len) begin
            w_state_d = W_RESP;
            bvalid_d  = 1'b1;
            b_d.id    = aw_q.id;
            b_d.resp  = w_err_d ? RESP_SLVERR : RESP_OKAY;
          end else begin
            w_cnt_d = w_cnt_q + 8'd1;
          end
        end
      end
      W_RESP: begin
        if (i_axi_s_bready) begin
          bvalid_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      aw_q      <= '0;
      w_cnt_q   <= 8'd0;
      w_err_q   <= 1'b0;
      b_q       <= '0;
      bvalid_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      aw_q      <= aw_d;
      w_cnt_q   <= w_cnt_d;
      w_err_q   <= w_err_d;
      b_q       <= b_d;
      bvalid_q  <= bvalid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int lane = 0; lane < STRB_W; lane++) begin
        if (i_axi_s_w.strb[lane]) mem[w_idx][8*lane +: 8] <= i_axi_s_w.data[8*lane +: 8];
      end
    end
  end

  // ---------------- read engine ----------------
  r_state_e          r_state_q, r_state_d;
  axi_ar_t           ar_q, ar_d;
  logic [7:0]        r_cnt_q, r_cnt_d;
  logic              rvalid_q, rvalid_d;
  logic [ID_W-1:0]   r_id_q, r_id_d;
  logic [1:0]        r_resp_q, r_resp_d;
  logic              r_last_q, r_last_d;
  logic [DATA_W-1:0] rd_data_q;
  logic              r_load;

  logic [ADDR_W-1:0] rg_addr;
  logic [2:0]        rg_size;
  logic [1:0]        rg_burst;
  logic [7:0]        rg_cnt, rg_len;
  logic [ID_W-1:0]   rg_id;
  logic [IDX_W-1:0]  r_idx;
  logic              r_in_range, r_legal, r_beat_err;

  // The beat being fetched is either beat 0 of a fresh AR or the successor of the one on R.
  always_comb begin
    if (r_state_q == R_IDLE) begin
      rg_addr  = i_axi_s_ar.addr;
      rg_size  = i_axi_s_ar.size;
      rg_burst = i_axi_s_ar.burst;
      rg_len   = i_axi_s_ar.len;
      rg_id    = i_axi_s_ar.id;
      rg_cnt   = 8'd0;
    end else begin
      rg_addr  = ar_q.addr;
      rg_size  = ar_q.size;
      rg_burst = ar_q.burst;
      rg_len   = ar_q.len;
      rg_id    = ar_q.id;
      rg_cnt   = r_cnt_q + 8'd1;
    end
  end

  axi_mem_sub_addr_gen #(
    .DEPTH    (DEPTH),
    .BASE_ADDR(BASE_ADDR),
    .IDX_W    (IDX_W)
  ) u_r_addr_gen (
    .i_start_addr(rg_addr),
    .i_size      (rg_size),
    .i_burst     (rg_burst),
    .i_beat_cnt  (rg_cnt),
    .o_word_idx  (r_idx),
    .o_in_range  (r_in_range),
    .o_legal     (r_legal)
  );

  assign r_beat_err      = !r_in_range || !r_legal;
  assign o_axi_s_arready = init_done_q && (r_state_q == R_IDLE);
  assign o_axi_s_rvalid  = rvalid_q;
  assign o_axi_s_r       = '{id: r_id_q, data: rvalid_q ? rd_data_q : '0,
                             resp: r_resp_q, last: r_last_q};

  always_comb begin
    r_state_d = r_state_q;
    ar_d      = ar_q;
    r_cnt_d   = r_cnt_q;
    rvalid_d  = rvalid_q;
    r_id_d    = r_id_q;
    r_resp_d  = r_resp_q;
    r_last_d  = r_last_q;
    r_load    = 1'b0;
    unique case (r_state_q)
      R_IDLE: begin
        if (i_axi_s_arvalid && o_axi_s_arready) begin
          ar_d      = i_axi_s_ar;
          r_cnt_d   = 8'd0;
          r_load    = 1'b1;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (i_axi_s_rready) begin
          if (r_last_q) begin
            rvalid_d  = 1'b0;
            r_state_d = R_IDLE;
          end else begin
            r_cnt_d = r_cnt_q + 8'd1;
            r_load  = 1'b1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    if (r_load) begin
      rvalid_d = 1'b1;
      r_id_d   = rg_id;
      r_resp_d = r_beat_err ? RESP_SLVERR : RESP_OKAY;
      r_last_d = (rg_cnt == rg_len);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= R_IDLE;
      ar_q      <= '0;
      r_cnt_q   <= 8'd0;
      rvalid_q  <= 1'b0;
      r_id_q    <= '0;
      r_resp_q  <= 2'd0;
      r_last_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      ar_q      <= ar_d;
      r_cnt_q   <= r_cnt_d;
      rvalid_q  <= rvalid_d;
      r_id_q    <= r_id_d;
      r_resp_q  <= r_resp_d;
      r_last_q  <= r_last_d;
    end
  end

  // Registered read port; a concurrent write to the same word is seen only by later beats.
  always_ff @(posedge clk) begin
    if (r_load) rd_data_q <= r_beat_err ? '0 : mem[r_idx];
  end

`ifdef AXI_MEM_SUB_PROTO_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst_n && (w_state_q == W_DATA) && i_axi_s_wvalid && w_last_mismatch)
      $error("axi_mem_sub: wlast=%0b disagrees with beat %0d of len %0d",
             i_axi_s_w.last, w_cnt_q, aw_q.len);
  end

  property p_aw_stable;
    @(posedge clk) disable iff (!rst_n)
      i_axi_s_awvalid && !o_axi_s_awready |=> i_axi_s_awvalid && $stable(i_axi_s_aw);
  endproperty

  property p_ar_stable;
    @(posedge clk) disable iff (!rst_n)
      i_axi_s_arvalid && !o_axi_s_arready |=> i_axi_s_arvalid && $stable(i_axi_s_ar);
  endproperty

  a_aw_stable: assert property (p_aw_stable) else $error("axi_mem_sub: AW dropped or changed before handshake");
  a_ar_stable: assert property (p_ar_stable) else $error("axi_mem_sub: AR dropped or changed before handshake");
`endif

endmodule
